mem_line_responder: RTL
=======================

// Module: mem_line_responder
// PURPOSE
//  Memory-side responder for the SA_Cache line-fill/evict interface. Services
//  cache misses by returning a full line after a fixed latency with a 1-cycle
//  response pulse, and absorbs dirty-line evictions into a backing line store.
//  Sits between the cache and the off-chip memory model or controller.
// PARAMETERS
//  LINE_SIZE_BYTES  64   bytes per line; LINE_SIZE_BITS = 8*LINE_SIZE_BYTES
//  ADDRESS_WIDTH    32   byte-address width
//  OFFSET_BITS      6    log2(LINE_SIZE_BYTES); ignored address LSBs
//  MEM_LINES        1024 backing-store depth in lines; MEM_IDX = $clog2(MEM_LINES)
//  READ_LATENCY     4    cycles from request accept to o_response (>=1)
//  WRITE_LATENCY    2    cycles a writeback occupies the store (>=1)
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               asynchronous, active-high reset
//  i_req          in   1               line-fill request, level (cache_miss)
//  i_req_addr     in   ADDRESS_WIDTH   byte address of requested line
//  o_line         out  LINE_SIZE_BITS  returned line, valid when o_response=1
//  o_response     out  1               1-cycle pulse: o_line valid
//  i_evict        in   1               1-cycle writeback strobe
//  i_evict_addr   in   ADDRESS_WIDTH   byte address of evicted line
//  i_evict_data   in   LINE_SIZE_BITS  evicted line data
//  o_evict_ready  out  1               evict buffer free; i_evict ignored when 0
//  o_busy         out  1               FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, any time, mid-op included): state=IDLE, o_line=0,
//    o_response=0, o_evict_ready=1, o_busy=0, latency counter=0, evict buffer
//    emptied (pending writeback discarded). Store contents NOT reset.
//  - Line index = addr[OFFSET_BITS +: MEM_IDX]; higher bits ignored (aliases).
//  - Evict buffer: one entry {idx,data}. On edge with i_evict&&o_evict_ready,
//    capture and drop o_evict_ready next cycle. Cleared when WB completes;
//    o_evict_ready rises the cycle after the store write.
//  - FSM states IDLE, WB, READ, RESP, COOL:
//    IDLE: buffer full -> WB (priority over i_req, gives read-after-evict
//          coherency). Else i_req=1 -> latch index, counter=READ_LATENCY-1, READ.
//    WB:   count WRITE_LATENCY cycles; store[idx]<=data on last cycle; -> IDLE.
//    READ: decrement; at 0 load o_line<=store[idx], -> RESP. Accepted at edge T
//          => o_response high in cycle following edge T+READ_LATENCY.
//    RESP: o_response=1 exactly this cycle; o_line held until next response.
//          -> COOL.
//    COOL: one cycle; i_req ignored (cache deasserts miss 1 cycle after
//          response); -> IDLE.
//  - i_evict accepted in any state while o_evict_ready=1, incl. same edge as a
//    request accept; that WB runs after the current read completes.
//  - i_req dropping during READ does not abort; response still issued.
//  - i_req_addr sampled only at accept; later changes ignored.
//  - Evict and read to same index accepted same IDLE edge: WB first, read
//    returns evicted data.
// TESTING
//  1. Reset mid-READ: rst pulse -> o_response never fires, o_busy=0, o_line=0,
//     o_evict_ready=1 asynchronously.
//  2. Evict addr 0x40 data 0xA5.. then i_req addr 0x40 -> o_response after
//     WB (2) + READ_LATENCY (4) cycles, o_line=0xA5.. pattern.
//  3. Single i_req held high through response -> exactly one o_response pulse;
//     COOL blocks re-accept; new request needs i_req high in IDLE.
//  4. Second i_evict while buffer full -> ignored, store keeps first data;
//     o_evict_ready=0 until the first WB completes.
//  5. Alias: evict to 0x0001_0040 (MEM_LINES=1024) then read 0x40 -> same line.
//  6. READ_LATENCY=1, WRITE_LATENCY=1 build: back-to-back evict/read pairs
//     return correct data with minimum latencies.

Source files
------------

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - memory-side line-fill/evict responder with a one-entry writeback buffer
// Returns a full line a fixed latency after a miss; evictions are absorbed through a single buffer entry.
module mem_line_responder #(
    parameter  int LINE_SIZE_BYTES = 64,
    parameter  int ADDRESS_WIDTH   = 32,
    parameter  int OFFSET_BITS     = 6,
    parameter  int MEM_LINES       = 1024,
    parameter  int READ_LATENCY    = 4,
    parameter  int WRITE_LATENCY   = 2,
    localparam int LINE_SIZE_BITS  = 8 * LINE_SIZE_BYTES,
    localparam int MEM_IDX         = $clog2(MEM_LINES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDRESS_WIDTH-1:0]  i_req_addr,
    output logic [LINE_SIZE_BITS-1:0] o_line,
    output logic                      o_response,
    input  logic                      i_evict,
    input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
    input  logic [LINE_SIZE_BITS-1:0] i_evict_data,
    output logic                      o_evict_ready,
    output logic                      o_busy
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WB_INIT = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_READ,
        S_RESP,
        S_COOL
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [MEM_IDX-1:0]        rd_idx_q, rd_idx_d;
    logic                      rd_pend_q, rd_pend_d;
    logic                      buf_valid_q, buf_valid_d;
    logic [MEM_IDX-1:0]        buf_idx_q, buf_idx_d;
    logic [LINE_SIZE_BITS-1:0] buf_data_q, buf_data_d;
    logic [LINE_SIZE_BITS-1:0] line_q, line_d;
    logic                      resp_q, resp_d;
    logic                      busy_q, busy_d;
    logic                      mem_we;
    logic                      evict_acc;

    logic [LINE_SIZE_BITS-1:0] store [MEM_LINES];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_addr[OFFSET_BITS-1:0],
                                i_req_addr[ADDRESS_WIDTH-1:OFFSET_BITS+MEM_IDX],
                                i_evict_addr[OFFSET_BITS-1:0],
                                i_evict_addr[ADDRESS_WIDTH-1:OFFSET_BITS+MEM_IDX]};

    assign evict_acc     = i_evict && !buf_valid_q;
    assign o_line        = line_q;
    assign o_response    = resp_q;
    assign o_evict_ready = !buf_valid_q;
    assign o_busy        = busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_idx_d    = rd_idx_q;
        rd_pend_d   = rd_pend_q;
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        buf_data_d  = buf_data_q;
        line_d      = line_q;
        resp_d      = 1'b0;
        mem_we      = 1'b0;

        if (evict_acc) begin
            buf_valid_d = 1'b1;
            buf_idx_d   = i_evict_addr[OFFSET_BITS +: MEM_IDX];
            buf_data_d  = i_evict_data;
        end

        case (state_q)
            S_IDLE: begin
                // Writeback first so a read to the evicted line sees the new data.
                if (buf_valid_q || evict_acc) begin
                    state_d = S_WB;
                    cnt_d   = WB_INIT;
                    if (!buf_valid_q && i_req) begin
                        rd_pend_d = 1'b1;
                        rd_idx_d  = i_req_addr[OFFSET_BITS +: MEM_IDX];
                    end
                end else if (i_req) begin
                    state_d  = S_READ;
                    cnt_d    = RD_INIT;
                    rd_idx_d = i_req_addr[OFFSET_BITS +: MEM_IDX];
                end
            end
            S_WB: begin
                if (cnt_q == '0) begin
                    mem_we      = 1'b1;
                    buf_valid_d = 1'b0;
                    if (rd_pend_q) begin
                        rd_pend_d = 1'b0;
                        cnt_d     = RD_INIT;
                        state_d   = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    line_d  = store[rd_idx_q];
                    resp_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_COOL;
            S_COOL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_idx_q    <= '0;
            rd_pend_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_data_q  <= '0;
            line_q      <= '0;
            resp_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            rd_pend_q   <= rd_pend_d;
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_data_q  <= buf_data_d;
            line_q      <= line_d;
            resp_q      <= resp_d;
            busy_q      <= busy_d;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            store[buf_idx_q] <= buf_data_q;
        end
    end

endmodule
